// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: binary/Gray read pointer, RAM read address, registered status.
// rd_valid one cycle after an accepted read; reads while empty are refused and flagged sticky.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray_sync,
  input  logic                  underflow_clr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          valid_q, valid_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] wbin;
  logic          rd_accept;

  always_comb begin
    rd_accept = rd_en & ~empty_q;
    rbin_d    = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_accept};
    rgray_d   = rbin_d ^ (rbin_d >> 1);

    wbin         = '0;
    wbin[PW-1]   = w_ptr_gray_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ w_ptr_gray_sync[i];
    end

    // Status is derived from the post-read pointer so the last read lands on empty with no bubble.
    level_d        = wbin - rbin_d;
    empty_d        = (rgray_d == w_ptr_gray_sync);
    almost_empty_d = (level_d <= AE_TH);
    valid_d        = rd_accept;
    underflow_d    = (rd_en & empty_q) | (underflow_q & ~underflow_clr);
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      valid_q        <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      valid_q        <= valid_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_addr         = rbin_q[ADDR_WIDTH-1:0];
  assign r_ptr_gray      = rgray_q;
  assign rd_valid        = valid_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = almost_empty_q;
  assign rd_level        = level_q;
  assign rd_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: directed vectors queue expected post-edge outputs,
// a monitor compares them one edge later.
module tb_fifo_rd_ctrl;

  logic       rd_clk;
  logic       rd_rst;
  logic       rd_en;
  logic [3:0] w_ptr_gray_sync;
  logic       underflow_clr;
  logic [2:0] rd_addr;
  logic [3:0] r_ptr_gray;
  logic       rd_valid;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic [3:0] rd_level;
  logic       rd_underflow;

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .ALMOST_EMPTY_TH(1)) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rd_en           (rd_en),
    .w_ptr_gray_sync (w_ptr_gray_sync),
    .underflow_clr   (underflow_clr),
    .rd_addr         (rd_addr),
    .r_ptr_gray      (r_ptr_gray),
    .rd_valid        (rd_valid),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       e;
    logic       ae;
    logic [3:0] lvl;
    logic       uf;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t x);
    chk({tag, " rd_addr"},         int'(rd_addr),         int'(x.addr));
    chk({tag, " r_ptr_gray"},      int'(r_ptr_gray),      int'(x.gray));
    chk({tag, " rd_empty"},        int'(rd_empty),        int'(x.e));
    chk({tag, " rd_almost_empty"}, int'(rd_almost_empty), int'(x.ae));
    chk({tag, " rd_level"},        int'(rd_level),        int'(x.lvl));
    chk({tag, " rd_underflow"},    int'(rd_underflow),    int'(x.uf));
    chk({tag, " rd_valid"},        int'(rd_valid),        int'(x.v));
  endtask

  function automatic logic [3:0] g(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  // Monitor: samples 2 time units after each edge and retires the records aimed at that edge.
  always begin
    @(posedge rd_clk);
    edge_n++;
    #2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
      exp_t x;
      x = exp_q.pop_front();
      if (x.cyc != edge_n) chk("scoreboard_order", x.cyc, edge_n);
      else chk_all("mon", x);
    end
  end

  // Apply one vector (called at posedge+1) and queue the outputs expected after the next edge.
  task automatic step(input logic en, input logic [3:0] wg, input logic clr,
                      input int addr, input int gray, input logic e, input logic ae,
                      input int lvl, input logic uf, input logic v);
    exp_t x;
    rd_en           = en;
    w_ptr_gray_sync = wg;
    underflow_clr   = clr;
    x.cyc  = edge_n + 1;
    x.addr = 3'(addr);
    x.gray = 4'(gray);
    x.e    = e;
    x.ae   = ae;
    x.lvl  = 4'(lvl);
    x.uf   = uf;
    x.v    = v;
    exp_q.push_back(x);
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  exp_t rst_exp;

  initial begin
    rst_exp = '{cyc: 0, addr: 0, gray: 0, e: 1, ae: 1, lvl: 0, uf: 0, v: 0};
    rd_rst = 1'b1;
    rd_en = 1'b0;
    w_ptr_gray_sync = 4'b0000;
    underflow_clr = 1'b0;
    #1 rd_rst = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    chk_all("reset", rst_exp);
    rd_rst = 1'b1;

    //   en  wg       clr addr gray    e  ae lvl uf v
    step(0, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 0, 0);
    step(1, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 1, 0); // read while empty
    step(0, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 1, 0);
    step(0, 4'b0010, 1,  0, 4'b0000, 0, 0, 3, 0, 0); // 3 words appear
    step(1, 4'b0010, 0,  1, 4'b0001, 0, 0, 2, 0, 1);
    step(1, 4'b0010, 0,  2, 4'b0011, 0, 1, 1, 0, 1);
    step(1, 4'b0010, 0,  3, 4'b0010, 1, 1, 0, 0, 1); // empty right after last read
    step(0, 4'b0010, 0,  3, 4'b0010, 1, 1, 0, 0, 0);
    step(1, 4'b0010, 0,  3, 4'b0010, 1, 1, 0, 1, 0);
    step(1, 4'b0010, 1,  3, 4'b0010, 1, 1, 0, 1, 0); // set beats clear
    step(0, 4'b0010, 1,  3, 4'b0010, 1, 1, 0, 0, 0);

    // Wrap: writer one Gray step ahead each cycle, reader follows through 15 -> 0.
    step(0, 4'b0110, 0,  3, 4'b0010, 0, 1, 1, 0, 0);
    for (int k = 5; k <= 16; k++) begin
      step(1, g(k), 0, (k - 1) % 8, g(k - 1), 0, 1, 1, 0, 1);
    end
    step(1, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 0, 1);

    // Full: pointers differ only in the MSB.
    step(0, 4'b1100, 0,  0, 4'b0000, 0, 0, 8, 0, 0);
    step(1, 4'b1101, 0,  1, 4'b0001, 0, 0, 8, 0, 1); // write and read same cycle
    step(1, 4'b1101, 0,  2, 4'b0011, 0, 0, 7, 0, 1);
    step(1, 4'b1101, 0,  3, 4'b0010, 0, 0, 6, 0, 1);
    step(1, 4'b1101, 0,  4, 4'b0110, 0, 0, 5, 0, 1);
    step(1, 4'b1101, 0,  5, 4'b0111, 0, 0, 4, 0, 1);

    // Reset lands in the middle of a read cycle with rbin = 5.
    rd_en = 1'b1;
    #2;
    rd_rst = 1'b0;
    #1;
    chk_all("async_reset", rst_exp);
    w_ptr_gray_sync = 4'b0000;
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b1;
    step(1, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 1, 0);
    step(0, 4'b0000, 0,  0, 4'b0000, 1, 1, 0, 1, 0);

    repeat (2) @(posedge rd_clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-domain pointer and status controller for the asynchronous FIFO. It takes the write Gray pointer after it has been passed through the two-flop w2r synchronizer, runs in rd_clk, and does four things: keeps the read pointer in binary and Gray form, drives the dual-port RAM read address, produces registered empty / almost-empty / level status, and exports the read Gray pointer to the r2w synchronizer.

Parameters:
- ADDR_WIDTH, 3, RAM address width. Depth = 2**ADDR_WIDTH. Pointer width PW = ADDR_WIDTH+1 (4 by default).
- ALMOST_EMPTY_TH, 1, rd_almost_empty asserts when occupancy <= this value. Legal range 0 .. 2**ADDR_WIDTH.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  read-domain reset, asynchronous, active-low.
- rd_en  in  1  read request from the consumer.
- w_ptr_gray_sync  in  PW  write Gray pointer, already synchronized into rd_clk.
- underflow_clr  in  1  clears the sticky rd_underflow flag.
- rd_addr  out  ADDR_WIDTH  RAM read address; equals rbin[ADDR_WIDTH-1:0].
- r_ptr_gray  out  PW  registered read Gray pointer, sent to the r2w synchronizer.
- rd_valid  out  1  RAM read data valid; one-cycle pulse one cycle after an accepted read.
- rd_empty  out  1  FIFO empty.
- rd_almost_empty  out  1  occupancy <= ALMOST_EMPTY_TH.
- rd_level  out  PW  conservative occupancy count, 0 .. 2**ADDR_WIDTH.
- rd_underflow  out  1  sticky flag: a read was attempted while empty.

Behaviour:
- Reset (rd_rst=0, asynchronous) forces all state and outputs:
  - rbin=0, r_ptr_gray=0, rd_addr=0
  - rd_empty=1, rd_almost_empty=1, rd_level=0
  - rd_valid=0, rd_underflow=0
- Accept rule: rd_accept = rd_en & ~rd_empty, evaluated against the registered rd_empty.
- Pointer update:
  - rbin_next = rbin + rd_accept, modulo 2**PW, so it wraps from all-ones to 0.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - Both registers update every rd_clk edge.
  - r_ptr_gray changes by at most one bit per cycle.
- RAM address: rd_addr comes straight from the rbin register (no combinational path from rd_en). The RAM is synchronous-read, so rd_valid <= rd_accept and data is valid while rd_valid=1.
- Empty:
  - rd_empty <= (rgray_next == w_ptr_gray_sync).
  - Computing from the next-state pointer means the last read deasserts nothing late: rd_empty is 1 in the cycle immediately after the final accepted read, with no extra bubble.
- Level:
  - wbin = Gray-to-binary of w_ptr_gray_sync, as an XOR prefix from the MSB down.
  - rd_level <= (wbin - rbin_next) mod 2**PW.
  - The value is never larger than the true occupancy, because the synchronized write pointer lags.
- Almost empty: rd_almost_empty <= (level_next <= ALMOST_EMPTY_TH), using the same level_next value as rd_level.
- Underflow:
  - rd_en & rd_empty sets rd_underflow on the next edge.
  - underflow_clr alone clears it.
  - Set and clear in the same cycle: set wins.
  - An underflow attempt never moves the pointer and never pulses rd_valid.
- Write pointer advancing during a read (same cycle): empty and level use the new w_ptr_gray_sync together with rbin_next. No read is lost and none is double-counted.
- Full wrap: when the pointers differ only in the MSB (binary difference = 2**ADDR_WIDTH), rd_level = 2**ADDR_WIDTH and rd_empty=0.
- Reset asserted mid-burst: the pointer returns to 0 immediately, and no rd_valid pulse follows a read cycle that is cut off by reset. The write side must be reset in the same window; this block does not check that.
- Status outputs (rd_empty, rd_almost_empty, rd_level) are registered only, with no combinational outputs.

Test Plan:
- Reset, then hold w_ptr_gray_sync=0000 → rd_empty=1, rd_almost_empty=1, rd_level=0, r_ptr_gray=0000. Pulse rd_en → rd_underflow=1, rbin stays 0, rd_valid stays 0.
- Set w_ptr_gray_sync=0010 (binary 3) → next edge: rd_empty=0, rd_level=3, rd_almost_empty=0.
  - Then rd_en=1 for 3 cycles → rd_addr 0,1,2; r_ptr_gray 0001,0011,0010.
  - rd_level after each read: 2, 1, 0; rd_almost_empty=1 once level=1.
  - rd_empty=1 the cycle after the 3rd read; rd_valid high for 3 cycles, delayed by 1.
- Wrap: advance the write pointer one Gray step at a time to binary 15, then to 0 (Gray 1000 → 0000), reading continuously → rbin wraps 15→0, r_ptr_gray 1000→0000, rd_addr 7→0, no spurious empty while rd_level>0.
- Full case: rbin=0, w_ptr_gray_sync=1100 (binary 8) → rd_level=8, rd_empty=0, rd_almost_empty=0.
- Underflow clear: rd_underflow=1. Assert rd_en (while empty) and underflow_clr in the same cycle → flag stays 1. Next cycle underflow_clr alone → flag 0.
- Mid-read reset: with rbin=5 and rd_en=1, pull rd_rst low asynchronously → all outputs return to reset values before the next rd_clk edge. No rd_valid pulse after reset is released.
